// File: rtl/bus_drive_sequencer.sv
// bus_drive_sequencer: serialises pending bus-drive requests into one-hot drives held until ack.
// Optional DRIVE_TIMEOUT_EN drops a drive that waits TIMEOUT cycles without ack.
module bus_drive_sequencer #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] req_in,
    input  logic             drive_ack,
    output logic [WIDTH-1:0] drive_out,
    output logic             drive_valid,
    output logic [WIDTH-1:0] pending_out,
    output logic             busy,
    output logic             dup_err,
    output logic             timeout_err
);
    typedef enum logic {IDLE, DRIVE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d, drive_q, drive_d, load_mask;
    logic busy_q, dup_q, load, done, tmo_hit;
    always_comb begin
        load_mask = '0;
        // Ascending scan so the highest set bit wins, matching the encoder.
        for (int i = 0; i < WIDTH; i++)
            if (pending_q[i]) load_mask = WIDTH'(1) << i;
        done      = (state_q == DRIVE) && (drive_ack || tmo_hit);
        load      = (|pending_q) && ((state_q == IDLE) || done);
        pending_d = (pending_q & ~(load ? load_mask : '0)) | req_in;
        drive_d   = load ? load_mask : done ? '0 : drive_q;
        state_d   = load ? DRIVE : done ? IDLE : state_q;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            pending_q <= '0;
            drive_q   <= '0;
            busy_q    <= 1'b0;
            dup_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            drive_q   <= drive_d;
            busy_q    <= (state_d == DRIVE) || (|pending_d);
            dup_q     <= dup_q || (|(req_in & pending_q));
        end
    end
`ifdef DRIVE_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic tmo_q;
    // Counter holds the number of un-acked cycles already spent on the current drive.
    assign tmo_hit = (state_q == DRIVE) && !drive_ack && (cnt_q == 8'(TIMEOUT - 1));
    assign cnt_d   = load ? 8'd0 : ((state_q == DRIVE) && !drive_ack) ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= 8'd0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_q || tmo_hit;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif
    assign drive_out   = drive_q;
    assign drive_valid = (state_q == DRIVE);
    assign pending_out = pending_q;
    assign busy        = busy_q;
    assign dup_err     = dup_q;
endmodule

// File: tb/tb_bus_drive_sequencer.sv
// tb_bus_drive_sequencer: directed plus random stimulus checked against a queue-free index-based model.
module tb_bus_drive_sequencer;
    localparam int TMO = 15;
    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [31:0] req_in = '0;
    logic drive_ack = 1'b0;
    logic [31:0] drive_out, pending_out;
    logic drive_valid, busy, dup_err, timeout_err;
    int total = 0;
    int bad = 0;
    logic [31:0] m_pend = '0;
    int m_cur = -1;
    int m_age = 0;
    bit m_dup = 1'b0;
    bit m_tmo = 1'b0;

    bus_drive_sequencer #(.WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .clr(clr), .req_in(req_in), .drive_ack(drive_ack),
        .drive_out(drive_out), .drive_valid(drive_valid), .pending_out(pending_out),
        .busy(busy), .dup_err(dup_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a set of pending source numbers and the number of the source on the bus (-1 = none).
    task automatic model(input logic [31:0] r, input logic a, input logic c);
        bit fin;
        int h;
        if (c) begin
            m_pend = '0; m_cur = -1; m_age = 0; m_dup = 0; m_tmo = 0;
            return;
        end
        if ((r & m_pend) != 0) m_dup = 1;
        fin = (m_cur >= 0) && a;
`ifdef DRIVE_TIMEOUT_EN
        if (m_cur >= 0 && !a && m_age == TMO) begin
            fin = 1;
            m_tmo = 1;
        end
`endif
        if (m_cur >= 0 && !fin) m_age++;
        if ((m_cur < 0 || fin) && m_pend != 0) begin
            h = -1;
            for (int i = 0; i < 32; i++) if (m_pend[i]) h = i;
            m_pend[h] = 1'b0;
            m_cur = h;
            m_age = 1;
        end else if (fin) m_cur = -1;
        m_pend |= r;
    endtask

    task automatic step(input logic [31:0] r, input logic a, input logic c);
        logic [31:0] exp_drv;
        @(negedge clk);
        req_in = r; drive_ack = a; clr = c;
        @(posedge clk);
        model(r, a, c);
        #1;
        exp_drv = (m_cur < 0) ? 32'd0 : (32'd1 << m_cur);
        chk("drive_out", drive_out, exp_drv);
        chk("drive_valid", {31'd0, drive_valid}, {31'd0, m_cur >= 0});
        chk("pending_out", pending_out, m_pend);
        chk("busy", {31'd0, busy}, {31'd0, (m_cur >= 0) || (m_pend != 0)});
        chk("dup_err", {31'd0, dup_err}, {31'd0, m_dup});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_tmo});
    endtask

    initial begin
        logic [31:0] r;
        int ack_pct;
        step(0, 0, 1);
        chk("reset_drive", drive_out, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        // clr mid-drive with upper pending bits
        step(32'hF0, 0, 0);
        step(0, 0, 0);
        chk("mid_drive", drive_out, 32'h80);
        chk("mid_pend", pending_out, 32'h70);
        step(0, 1, 1);
        chk("clr_drive", drive_out, 32'd0);
        chk("clr_pend", pending_out, 32'd0);
        chk("clr_valid", {31'd0, drive_valid}, 32'd0);
        // single request latency with ack tied high
        step(32'h1, 1, 0);
        chk("lat_t1", drive_out, 32'd0);
        step(0, 1, 0);
        chk("lat_t2", drive_out, 32'h1);
        step(0, 1, 0);
        chk("lat_t3_valid", {31'd0, drive_valid}, 32'd0);
        chk("lat_t3_busy", {31'd0, busy}, 32'd0);
        // priority sequence
        step(32'h8000_0012, 1, 0);
        step(0, 1, 0);
        chk("seq0", drive_out, 32'h8000_0000);
        step(0, 1, 0);
        chk("seq1", drive_out, 32'h10);
        step(0, 1, 0);
        chk("seq2", drive_out, 32'h2);
        step(0, 1, 0);
        chk("seq3", drive_out, 32'h0);
        // re-request of the bit on the bus, then a duplicate
        step(0, 0, 1);
        step(32'h20, 0, 0);
        step(0, 0, 0);
        step(32'h20, 0, 0);
        chk("redrv_pend", pending_out, 32'h20);
        chk("redrv_nodup", {31'd0, dup_err}, 32'd0);
        step(32'h20, 0, 0);
        chk("redrv_dup", {31'd0, dup_err}, 32'd1);
        step(0, 1, 0);
        chk("redrv_again", drive_out, 32'h20);
        step(0, 1, 0);
        chk("redrv_once", drive_out, 32'h0);
        // request coinciding with its own load edge
        step(0, 0, 1);
        step(32'h08, 0, 0);
        step(32'h08, 0, 0);
        chk("coin_drive", drive_out, 32'h08);
        chk("coin_pend", pending_out, 32'h08);
        step(0, 1, 0);
        chk("coin_second", drive_out, 32'h08);
        step(0, 1, 0);
        chk("coin_idle", drive_out, 32'h0);
`ifdef DRIVE_TIMEOUT_EN
        step(0, 0, 1);
        step(32'h0C, 0, 0);
        for (int k = 0; k < TMO; k++) step(0, 0, 0);
        chk("tmo_held", drive_out, 32'h08);
        step(0, 0, 0);
        chk("tmo_next", drive_out, 32'h04);
        chk("tmo_err", {31'd0, timeout_err}, 32'd1);
        step(0, 0, 1);
        step(32'h0C, 0, 0);
        for (int k = 0; k < TMO; k++) step(0, 0, 0);
        step(0, 1, 0);
        chk("tmo_ack_next", drive_out, 32'h04);
        chk("tmo_ack_noerr", {31'd0, timeout_err}, 32'd0);
`endif
        // random traffic with varying ack density and occasional clr
        for (int p = 0; p < 4; p++) begin
            ack_pct = 10 + p * 30;
            for (int k = 0; k < 600; k++) begin
                r = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'd0;
                step(r, $urandom_range(0, 99) < ack_pct, $urandom_range(0, 149) == 0);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_drive_sequencer.md
Name: bus_drive_sequencer

Overview:
- Upstream of the 32-to-5 bus-select priority encoder.
- Collects drive requests from the 32 bus sources (R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C, ...) into a pending register.
- Serialises them so the encoder always sees at most one asserted line, held until the bus transfer is acknowledged.
- Removes multi-source collisions on the shared bus.

Parameters:
- WIDTH, 32, number of request/drive lines; must equal encoder input width.
- TIMEOUT, 15, cycles a drive may wait for ack before being dropped (DRIVE_TIMEOUT_EN only); range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- req_in  in  WIDTH  request pulses; bit i high for one or more cycles requests one drive by source i.
- drive_ack  in  1  consumer accepted the current drive (bus transfer complete).
- drive_out  out  WIDTH  one-hot or all-zero drive vector to the encoder input.
- drive_valid  out  1  drive_out holds a live one-hot value.
- pending_out  out  WIDTH  registered pending-request vector, excluding the bit currently driven.
- busy  out  1  drive_valid OR (pending_out != 0).
- dup_err  out  1  sticky; a request hit a bit already pending.
- timeout_err  out  1  sticky; a drive was dropped on timeout (tied 0 without DRIVE_TIMEOUT_EN).

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-high (clk, clr). All outputs are registered.
- Reset: when clr is high at the edge, these clear to 0: drive_out, drive_valid, pending_out, dup_err, timeout_err, timeout counter. State goes to IDLE. clr overrides all other inputs in that cycle, including mid-drive.
- Pending update each edge: pending_next = (pending & ~load_mask) | req_in.
  - Set wins over clear: a bit requested on the same edge it is loaded stays pending for a second drive.
- Selection: fixed priority, highest index wins, matching encoder priority. load_mask is a one-hot of the highest set bit of the registered pending.
- FSM states:
  - IDLE: drive_valid=0. If pending != 0: load drive_out <= load_mask, clear that bit from pending, drive_valid <= 1, go to DRIVE. Else stay.
  - DRIVE: drive_out held stable and drive_valid=1 until drive_ack.
    - On ack with pending != 0: load next highest bit on the same edge. drive_valid stays 1 and drive_out changes directly to the new one-hot. Stay in DRIVE.
    - On ack with pending == 0: drive_out <= 0, drive_valid <= 0, go to IDLE.
- Latency: req_in bit asserted in cycle t while IDLE and empty -> pending bit set after edge t -> drive_out valid in cycle t+2.
- Throughput: back-to-back acks give one new drive per cycle.
- drive_ack while IDLE is ignored.
- A request for the bit currently being driven becomes a new pending request; it is not merged.
- dup_err sets when req_in[i] & pending[i] at an edge. It stays set until clr.
- Invariant: drive_out is never multi-hot. drive_out == 0 iff drive_valid == 0.

Optional Feature:
- Macro: DRIVE_TIMEOUT_EN.
- Defined:
  - An 8-bit counter resets to 0 on each load and increments each DRIVE cycle without ack.
  - When the counter reaches TIMEOUT with no ack, the drive is dropped (no retry) and timeout_err sets (sticky).
  - The next pending bit loads on that same edge, else the FSM returns to IDLE.
  - Ack on the timeout cycle wins: a normal completion, no error.
- Undefined: no counter. DRIVE waits indefinitely. timeout_err is tied 0.

Test Plan:
- clr high mid-DRIVE with pending=0x0000_00F0 -> next cycle all outputs 0, state IDLE; a req_in later behaves as from reset.
- req_in=0x0000_0001 for one cycle at t, drive_ack tied high -> drive_out=0x1, drive_valid=1 at t+2; drive_valid=0 at t+3; busy low at t+3.
- req_in=0x8000_0012 in one cycle, drive_ack held high -> drive_out sequence 0x8000_0000, 0x0000_0010, 0x0000_0002 on consecutive cycles, then 0.
- Driving bit 5 with ack low, req_in=0x20 pulsed, then req_in=0x20 again -> pending_out=0x20 after first pulse, dup_err=1 after second; on ack, bit 5 is redriven once.
- Load edge of bit 3 coincides with req_in=0x08 -> bit 3 stays pending; second drive of 0x08 follows the first.
- DRIVE_TIMEOUT_EN, TIMEOUT=15, pending 0x0C, ack never asserted -> 0x08 driven 15 cycles, timeout_err=1, 0x04 loaded same edge; ack on the 15th cycle instead -> no error.
